// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use hazard detector.
// Captures the decoder control word, operands, register specifiers and next-PC
// each cycle. Supports flush (taken branch/jump) and a downstream hold.
// Optional feature macro: HAZARD_DETECT_EN
//   defined   -> load-use detection inserts a one-cycle bubble and freezes PC/IF-ID
//   undefined -> no detection; outStall follows inHold only
module id_ex_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CTRL_W     = 15
) (
   input  logic                  inClock,
   input  logic                  inReset,
   input  logic [CTRL_W-1:0]     inControl,
   input  logic [DATA_W-1:0]     inPCNext,
   input  logic [DATA_W-1:0]     inRegA,
   input  logic [DATA_W-1:0]     inRegB,
   input  logic [DATA_W-1:0]     inSignExt,
   input  logic [REG_ADDR_W-1:0] inRs,
   input  logic [REG_ADDR_W-1:0] inRt,
   input  logic [REG_ADDR_W-1:0] inRd,
   input  logic                  inFlush,
   input  logic                  inHold,
   output logic [CTRL_W-1:0]     outControl,
   output logic [DATA_W-1:0]     outPCNext,
   output logic [DATA_W-1:0]     outRegA,
   output logic [DATA_W-1:0]     outRegB,
   output logic [DATA_W-1:0]     outSignExt,
   output logic [REG_ADDR_W-1:0] outRs,
   output logic [REG_ADDR_W-1:0] outRt,
   output logic [REG_ADDR_W-1:0] outRd,
   output logic                  outValid,
   output logic                  outStall
);

   localparam int unsigned MEM_READ_BIT = 6;

   logic [CTRL_W-1:0]     r_control;
   logic [DATA_W-1:0]     r_pc_next;
   logic [DATA_W-1:0]     r_reg_a;
   logic [DATA_W-1:0]     r_reg_b;
   logic [DATA_W-1:0]     r_sign_ext;
   logic [REG_ADDR_W-1:0] r_rs;
   logic [REG_ADDR_W-1:0] r_rt;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_valid;
   logic                  w_hazard;

`ifdef HAZARD_DETECT_EN
   // Load in EX whose destination is read by the decode instruction (rs or rt, conservatively)
   assign w_hazard = r_valid & r_control[MEM_READ_BIT] & (r_rt != '0) &
                     ((r_rt == inRs) | (r_rt == inRt));
`else
   // No hardware interlock: software schedules a NOP after each load
   assign w_hazard = 1'b0;
`endif

   // Freeze request for PC and IF/ID; masked while reset is asserted
   assign outStall = inReset & (w_hazard | inHold);

   // Pipeline register update: flush > hold > load-use bubble > normal capture
   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         r_control  <= '0;
         r_pc_next  <= '0;
         r_reg_a    <= '0;
         r_reg_b    <= '0;
         r_sign_ext <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_valid    <= 1'b0;
      end else if (inFlush) begin
         r_control  <= '0;
         r_valid    <= 1'b0;
         r_pc_next  <= inPCNext;
         r_reg_a    <= inRegA;
         r_reg_b    <= inRegB;
         r_sign_ext <= inSignExt;
         r_rs       <= inRs;
         r_rt       <= inRt;
         r_rd       <= inRd;
      end else if (inHold) begin
         r_control  <= r_control;
         r_valid    <= r_valid;
      end else if (w_hazard) begin
         // Bubble: zero control so it never writes the register file or memory
         r_control  <= '0;
         r_valid    <= 1'b0;
         r_rt       <= '0;
         r_pc_next  <= inPCNext;
         r_reg_a    <= inRegA;
         r_reg_b    <= inRegB;
         r_sign_ext <= inSignExt;
         r_rs       <= inRs;
         r_rd       <= inRd;
      end else begin
         r_control  <= inControl;
         r_valid    <= 1'b1;
         r_pc_next  <= inPCNext;
         r_reg_a    <= inRegA;
         r_reg_b    <= inRegB;
         r_sign_ext <= inSignExt;
         r_rs       <= inRs;
         r_rt       <= inRt;
         r_rd       <= inRd;
      end
   end

   assign outControl = r_control;
   assign outPCNext  = r_pc_next;
   assign outRegA    = r_reg_a;
   assign outRegB    = r_reg_b;
   assign outSignExt = r_sign_ext;
   assign outRs      = r_rs;
   assign outRt      = r_rt;
   assign outRd      = r_rd;
   assign outValid   = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model of the ID/EX register and load-use interlock.
module tb_id_ex_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RA_W   = 5;
   localparam int unsigned CTRL_W = 15;

`ifdef HAZARD_DETECT_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CTRL_W-1:0] inControl;
   logic [DATA_W-1:0] inPCNext, inRegA, inRegB, inSignExt;
   logic [RA_W-1:0]   inRs, inRt, inRd;
   logic              inFlush, inHold;
   logic [CTRL_W-1:0] outControl;
   logic [DATA_W-1:0] outPCNext, outRegA, outRegB, outSignExt;
   logic [RA_W-1:0]   outRs, outRt, outRd;
   logic              outValid, outStall;

   id_ex_stage dut (
      .inClock   (clk),
      .inReset   (rst_n),
      .inControl (inControl),
      .inPCNext  (inPCNext),
      .inRegA    (inRegA),
      .inRegB    (inRegB),
      .inSignExt (inSignExt),
      .inRs      (inRs),
      .inRt      (inRt),
      .inRd      (inRd),
      .inFlush   (inFlush),
      .inHold    (inHold),
      .outControl(outControl),
      .outPCNext (outPCNext),
      .outRegA   (outRegA),
      .outRegB   (outRegB),
      .outSignExt(outSignExt),
      .outRs     (outRs),
      .outRt     (outRt),
      .outRd     (outRd),
      .outValid  (outValid),
      .outStall  (outStall)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what EX should hold; m_dc marks data that is don't-care after a flush
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_pc, m_a, m_b, m_se;
   logic [RA_W-1:0]   m_rs, m_rt, m_rd;
   logic              m_valid, m_dc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl = '0; m_pc = '0; m_a = '0; m_b = '0; m_se = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_valid = 1'b0; m_dc = 1'b0;
   endtask

   function automatic bit model_hazard();
      return HZ && m_valid && m_ctrl[6] && (m_rt != 0) && ((m_rt == inRs) || (m_rt == inRt));
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, ".ctrl"},  32'(outControl), 32'(m_ctrl));
      chk({tag, ".valid"}, 32'(outValid),   32'(m_valid));
      if (!m_dc) begin
         chk({tag, ".pc"}, outPCNext,  m_pc);
         chk({tag, ".a"},  outRegA,    m_a);
         chk({tag, ".b"},  outRegB,    m_b);
         chk({tag, ".se"}, outSignExt, m_se);
         chk({tag, ".rs"}, 32'(outRs), 32'(m_rs));
         chk({tag, ".rt"}, 32'(outRt), 32'(m_rt));
         chk({tag, ".rd"}, 32'(outRd), 32'(m_rd));
      end
   endtask

   task automatic load_all();
      m_pc = inPCNext; m_a = inRegA; m_b = inRegB; m_se = inSignExt;
      m_rs = inRs; m_rt = inRt; m_rd = inRd;
   endtask

   // Drive a decode slot at the falling edge; unlisted data fields are random
   task automatic drive(input logic [CTRL_W-1:0] c, input logic [RA_W-1:0] rs,
                        input logic [RA_W-1:0] rt, input logic [RA_W-1:0] rd,
                        input logic [DATA_W-1:0] a, input logic fl, input logic ho);
      @(negedge clk);
      inControl = c; inRs = rs; inRt = rt; inRd = rd; inRegA = a;
      inPCNext = $urandom; inRegB = $urandom; inSignExt = $urandom;
      inFlush = fl; inHold = ho;
   endtask

   // Check the combinational stall, advance the model one edge, check registers
   task automatic step(input string tag);
      bit h;
      #1;
      h = model_hazard();
      chk({tag, ".stall"}, 32'(outStall), 32'(h | inHold));
      if (inFlush) begin
         m_ctrl = '0; m_valid = 1'b0; load_all(); m_dc = 1'b1;
      end else if (inHold) begin
         // registers keep their values
      end else if (h) begin
         m_ctrl = '0; m_valid = 1'b0; load_all(); m_rt = '0; m_dc = 1'b0;
      end else begin
         m_ctrl = inControl; m_valid = 1'b1; load_all(); m_dc = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outs(tag);
   endtask

   localparam logic [CTRL_W-1:0] C_RTYPE = 15'h0302;
   localparam logic [CTRL_W-1:0] C_LW    = 15'h0643;

   initial begin
      rst_n = 1'b0;
      inControl = '0; inPCNext = '0; inRegA = '0; inRegB = '0; inSignExt = '0;
      inRs = '0; inRt = '0; inRd = '0; inFlush = 1'b0; inHold = 1'b1;
      model_reset();
      #2;
      check_outs("rst");
      chk("rst.stall_masked", 32'(outStall), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      inHold = 1'b0;

      // Pass-through R-type
      drive(C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h5, 1'b0, 1'b0);
      step("pass");
      chk("pass.ctrl_const", 32'(outControl), 32'(C_RTYPE));
      chk("pass.rd_const",   32'(outRd), 32'd3);
      chk("pass.a_const",    outRegA, 32'h5);
      chk("pass.valid_const", 32'(outValid), 32'd1);

      // Load-use: lw rt=2 then add reading r2
      drive(C_LW, 5'd4, 5'd2, 5'd0, 32'h10, 1'b0, 1'b0);
      step("lu_lw");
      drive(C_RTYPE, 5'd2, 5'd3, 5'd5, 32'h77, 1'b0, 1'b0);
      #1;
      chk("lu.stall_const", 32'(outStall), 32'(HZ));
      step("lu_add");
      chk("lu.ex_ctrl", 32'(outControl), HZ ? 32'd0 : 32'(C_RTYPE));
      chk("lu.ex_valid", 32'(outValid), HZ ? 32'd0 : 32'd1);
      if (HZ) begin
         drive(C_RTYPE, 5'd2, 5'd3, 5'd5, 32'h77, 1'b0, 1'b0);
         #1;
         chk("lu.restall", 32'(outStall), 32'd0);
         step("lu_retry");
         chk("lu.retry_ctrl", 32'(outControl), 32'(C_RTYPE));
      end

      // Zero register is never a hazard
      drive(C_LW, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
      step("zr_lw");
      drive(C_RTYPE, 5'd0, 5'd0, 5'd6, 32'h9, 1'b0, 1'b0);
      step("zr_add");
      chk("zr.valid_const", 32'(outValid), 32'd1);

      // Flush beats hazard, and flush beats hold
      drive(C_LW, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0);
      step("fl_lw");
      drive(C_RTYPE, 5'd2, 5'd7, 5'd8, 32'h1, 1'b1, 1'b0);
      step("fl_hz");
      chk("fl_hz.ctrl_const", 32'(outControl), 32'd0);
      drive(C_RTYPE, 5'd1, 5'd3, 5'd4, 32'h2, 1'b0, 1'b0);
      step("fl_pre");
      drive(C_RTYPE, 5'd1, 5'd3, 5'd4, 32'h3, 1'b1, 1'b1);
      step("fl_hold");
      chk("fl_hold.valid_const", 32'(outValid), 32'd0);

      // Hold for three cycles
      drive(C_RTYPE, 5'd9, 5'd10, 5'd11, 32'hABCD, 1'b0, 1'b0);
      step("hold_pre");
      for (int i = 0; i < 3; i++) begin
         drive(15'(($urandom)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0, 1'b1);
         step("hold");
         chk("hold.a_const", outRegA, 32'hABCD);
      end

      // Asynchronous reset mid-stream
      drive(15'h0602, 5'd1, 5'd2, 5'd3, 32'h4, 1'b0, 1'b0);
      step("mid_pre");
      #2;
      rst_n = 1'b0;
      inHold = 1'b1;
      #1;
      model_reset();
      check_outs("mid_rst");
      chk("mid_rst.stall", 32'(outStall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      inHold = 1'b0;

      // Randomized traffic with a small register pool to provoke hazards
      for (int i = 0; i < 400; i++) begin
         logic [CTRL_W-1:0] c;
         c = 15'($urandom);
         c[6] = ($urandom_range(0, 1) == 1);
         drive(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
               $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the MIPS core, directly downstream of the opcode control decoder. Each cycle it captures the 15-bit control word plus decode operands, register specifiers and next-PC, and presents them to the execute stage. It also contains the load-use hazard detector: on a hazard it inserts a bubble into EX and requests a one-cycle freeze of PC and IF/ID. It supports branch/jump flush and a downstream hold.

## Interface
- DATA_W, 32, width of operands and PC
- REG_ADDR_W, 5, register specifier width
- CTRL_W, 15, control word width; fields [14:13] jump/link, [12:7] EX, [6] MemRead, [5] MemWrite, [4:2] mem size/sign, [1] RegWrite, [0] MemToReg
- inClock  in  1  clock; all state updates on the rising edge
- inReset  in  1  reset; one clock, reset asynchronous and active-low
- inControl  in  CTRL_W  control word from the decoder
- inPCNext  in  DATA_W  PC+4 of the decode instruction
- inRegA, inRegB  in  DATA_W  register file read data (rs, rt)
- inSignExt  in  DATA_W  sign-extended immediate
- inRs, inRt, inRd  in  REG_ADDR_W  decode register specifiers
- inFlush  in  1  kill the decode instruction (taken branch/jump)
- inHold  in  1  downstream stall: freeze this stage
- outControl  out  CTRL_W  registered control word
- outPCNext, outRegA, outRegB, outSignExt  out  DATA_W  registered data
- outRs, outRt, outRd  out  REG_ADDR_W  registered specifiers
- outValid  out  1  EX holds a real instruction (0 = bubble)
- outStall  out  1  combinational; freeze PC and IF/ID this cycle

## Operation
- Hazard condition H = outValid & outControl[6] & (outRt != 0) & ((outRt == inRs) | (outRt == inRt)). Both sources are compared regardless of instruction type; this is deliberately conservative.
- outStall = H | inHold.
- Next-state priority, evaluated on each rising edge:
  1. inFlush: outControl <= 0, outValid <= 0. Data and specifier registers load their inputs, but the values are don't-care.
  2. inHold: all registers keep their current values.
  3. H: bubble. outControl <= 0, outValid <= 0, outRt <= 0. Other registers load their inputs.
  4. Otherwise: all registers load their inputs and outValid <= 1.
- A bubble has a zero control word, so it never writes the register file or memory.
- Because the bubble clears outValid, H deasserts on the next cycle. A load-use stall therefore lasts exactly one cycle. The stalled decode instruction is re-presented and captured in the following cycle.
- inFlush together with H: the flush wins, and outStall is still driven from H for that cycle. This is harmless because upstream flush logic overrides it.
- inFlush together with inHold: the flush wins. A killed instruction must not linger.

## Timing
- Latency is one cycle from inputs to out* registers.
- outStall is combinational from the current registered state plus inRs, inRt and inHold, with no registers in the path. Budget it as one comparator level plus an AND-OR.
- While inReset = 0, all outputs are 0, including outValid = 0, and outStall = 0 (inHold masked). This applies asynchronously, both at reset and mid-operation.
- First capture is on the first rising edge after inReset deasserts.

## Configuration
- HAZARD_DETECT_EN
  - Defined: load-use detection and bubble insertion behave as described above.
  - Undefined: H is constant 0, so outStall = inHold and bubbles are never inserted. The compiler or software must schedule a NOP after each load. Flush and hold behaviour is unchanged.

## Test plan
- Reset mid-stream: assert inReset = 0 while outValid = 1 and outControl = 15'h0602 -> all outputs 0 immediately, without waiting for a clock edge.
- Pass-through: R-type, inControl = 15'h0302, inRs = 1, inRt = 2, inRd = 3, inRegA = 32'h5 -> next cycle outControl = 15'h0302, outRd = 3, outRegA = 32'h5, outValid = 1, outStall = 0.
- Load-use: lw with outRt = 2 and MemRead = 1 in EX, decode add with inRs = 2 -> outStall = 1 for one cycle, next EX is a bubble (outControl = 0, outValid = 0), then the add is captured with outStall = 0.
- Zero register: lw to rt = 0 in EX, decode inRs = 0 -> outStall = 0 and no bubble.
- Flush priority: H = 1 and inFlush = 1 in the same cycle -> next outControl = 0, outValid = 0. With inFlush = 1 and inHold = 1 -> next outControl = 0, outValid = 0.
- Hold: inHold = 1 for 3 cycles -> outputs unchanged and outStall = 1 throughout. Build with HAZARD_DETECT_EN undefined and repeat the load-use case -> outStall = 0 and the add is captured immediately.
